// File: rtl/coreriscv_axi4_grant_finish_unit_pkg.sv
// Shared definitions for the TileLink grant/finish unit: grant field widths,
// g_type encodings and the grant beat payload layout.
package coreriscv_axi4_grant_finish_unit_pkg;

  localparam int BEATS_PER_BLOCK = 8;
  localparam int BEAT_W          = 3;
  localparam int DATA_W          = 64;
  localparam int CLIENT_XACT_W   = 2;
  localparam int MANAGER_XACT_W  = 1;
  localparam int G_TYPE_W        = 4;

  // Builtin g_type values
  localparam logic [G_TYPE_W-1:0] G_TYPE_VOLUNTARY_ACK  = 4'd0;
  localparam logic [G_TYPE_W-1:0] G_TYPE_GET_DATA_BLOCK = 4'd5;
  // Non-builtin g_type value
  localparam logic [G_TYPE_W-1:0] G_TYPE_DATA           = 4'd0;

  // One grant beat as stored in the grant buffer
  typedef struct packed {
    logic [BEAT_W-1:0]         addr_beat;
    logic [CLIENT_XACT_W-1:0]  client_xact_id;
    logic [MANAGER_XACT_W-1:0] manager_xact_id;
    logic                      is_builtin_type;
    logic [G_TYPE_W-1:0]       g_type;
    logic [DATA_W-1:0]         data;
  } grant_t;

  localparam int GRANT_W = $bits(grant_t);

endpackage

// File: rtl/coreriscv_axi4_sync_fifo.sv
// Parameterized synchronous FIFO with registered full/empty flags.
// Push is ignored when full, pop is ignored when empty. Storage is cleared
// on reset so the read port shows zeros while empty after reset.
module coreriscv_axi4_sync_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage, pointers, occupancy and flags; flags are updated from the
  // pre-edge count so they stay registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      if (do_push && !do_pop) begin
        count <= count + CNT_W'(1);
        empty <= 1'b0;
        full  <= (count == CNT_W'(DEPTH - 1));
      end else if (!do_push && do_pop) begin
        count <= count - CNT_W'(1);
        full  <= 1'b0;
        empty <= (count == CNT_W'(1));
      end
    end
  end

endmodule

// File: rtl/coreriscv_axi4_grant_finish_unit.sv
// Grant finish unit: buffers the arbitrated TileLink grant stream toward the
// client and queues a Finish (manager_xact_id) once the last beat of a grant
// that needs acknowledgement is accepted.
// Optional beat-index checking: define CORERISCV_AXI4_GRANT_BEAT_CHECK_EN.
module coreriscv_axi4_grant_finish_unit
  import coreriscv_axi4_grant_finish_unit_pkg::*;
#(
  parameter int GRANT_DEPTH  = 2,
  parameter int FINISH_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        io_in_valid,
  output logic        io_in_ready,
  input  logic [2:0]  io_in_bits_addr_beat,
  input  logic [1:0]  io_in_bits_client_xact_id,
  input  logic [0:0]  io_in_bits_manager_xact_id,
  input  logic        io_in_bits_is_builtin_type,
  input  logic [3:0]  io_in_bits_g_type,
  input  logic [63:0] io_in_bits_data,
  output logic        io_out_valid,
  input  logic        io_out_ready,
  output logic [2:0]  io_out_bits_addr_beat,
  output logic [1:0]  io_out_bits_client_xact_id,
  output logic [0:0]  io_out_bits_manager_xact_id,
  output logic        io_out_bits_is_builtin_type,
  output logic [3:0]  io_out_bits_g_type,
  output logic [63:0] io_out_bits_data,
  output logic        io_finish_valid,
  input  logic        io_finish_ready,
  output logic [0:0]  io_finish_bits_manager_xact_id,
  output logic        io_beat_err
);

  grant_t            in_beat;
  grant_t            out_beat;
  logic [BEAT_W-1:0] beat_cnt;
  logic              multibeat;
  logic              needs_finish;
  logic              is_last;
  logic              in_fire;
  logic              grant_full;
  logic              grant_empty;
  logic              finish_full;
  logic              finish_empty;

  // Decode the incoming beat: multibeat, acknowledgement and last-beat status
  always_comb begin
    in_beat = '{
      addr_beat:       io_in_bits_addr_beat,
      client_xact_id:  io_in_bits_client_xact_id,
      manager_xact_id: io_in_bits_manager_xact_id,
      is_builtin_type: io_in_bits_is_builtin_type,
      g_type:          io_in_bits_g_type,
      data:            io_in_bits_data
    };
    multibeat    = ( io_in_bits_is_builtin_type && io_in_bits_g_type == G_TYPE_GET_DATA_BLOCK) ||
                   (!io_in_bits_is_builtin_type && io_in_bits_g_type == G_TYPE_DATA);
    needs_finish = !(io_in_bits_is_builtin_type && io_in_bits_g_type == G_TYPE_VOLUNTARY_ACK);
    is_last      = !multibeat || (beat_cnt == BEAT_W'(BEATS_PER_BLOCK - 1));
    // Finish-queue space only matters for the beat that would push a Finish.
    io_in_ready  = !grant_full && (!finish_full || !needs_finish || !is_last);
    in_fire      = io_in_valid && io_in_ready;
  end

  // Beat counter for multibeat grants; wraps after the last beat
  always_ff @(posedge clk or posedge reset) begin
    if (reset) beat_cnt <= '0;
    else if (in_fire && multibeat) beat_cnt <= beat_cnt + BEAT_W'(1);
  end

  coreriscv_axi4_sync_fifo #(
    .WIDTH (GRANT_W),
    .DEPTH (GRANT_DEPTH)
  ) u_grant_buf (
    .clk       (clk),
    .reset     (reset),
    .push      (in_fire),
    .push_data (in_beat),
    .pop       (io_out_ready),
    .pop_data  (out_beat),
    .full      (grant_full),
    .empty     (grant_empty)
  );

  coreriscv_axi4_sync_fifo #(
    .WIDTH (MANAGER_XACT_W),
    .DEPTH (FINISH_DEPTH)
  ) u_finish_q (
    .clk       (clk),
    .reset     (reset),
    .push      (in_fire && needs_finish && is_last),
    .push_data (io_in_bits_manager_xact_id),
    .pop       (io_finish_ready),
    .pop_data  (io_finish_bits_manager_xact_id),
    .full      (finish_full),
    .empty     (finish_empty)
  );

  assign io_out_valid                = !grant_empty;
  assign io_finish_valid             = !finish_empty;
  assign io_out_bits_addr_beat       = out_beat.addr_beat;
  assign io_out_bits_client_xact_id  = out_beat.client_xact_id;
  assign io_out_bits_manager_xact_id = out_beat.manager_xact_id;
  assign io_out_bits_is_builtin_type = out_beat.is_builtin_type;
  assign io_out_bits_g_type          = out_beat.g_type;
  assign io_out_bits_data            = out_beat.data;

`ifdef CORERISCV_AXI4_GRANT_BEAT_CHECK_EN
  logic beat_err;

  // Sticky flag: an accepted multibeat beat carried an unexpected beat index
  always_ff @(posedge clk or posedge reset) begin
    if (reset) beat_err <= 1'b0;
    else if (in_fire && multibeat && io_in_bits_addr_beat != beat_cnt) beat_err <= 1'b1;
  end

  assign io_beat_err = beat_err;
`else
  assign io_beat_err = 1'b0;
`endif

endmodule

// File: tb/tb_coreriscv_axi4_grant_finish_unit.sv
// Randomized self-checking bench for coreriscv_axi4_grant_finish_unit.
// Reference model: two queues (grant buffer and finish queue contents) plus a
// per-grant beat position, updated from the handshake rules each cycle.
module tb_coreriscv_axi4_grant_finish_unit;
  import coreriscv_axi4_grant_finish_unit_pkg::*;

  localparam int GD = 2;
  localparam int FD = 2;
  localparam int N_CYCLES = 2400;

  logic        clk = 1'b0;
  logic        reset;
  logic        io_in_valid;
  logic        io_in_ready;
  logic [2:0]  io_in_bits_addr_beat;
  logic [1:0]  io_in_bits_client_xact_id;
  logic [0:0]  io_in_bits_manager_xact_id;
  logic        io_in_bits_is_builtin_type;
  logic [3:0]  io_in_bits_g_type;
  logic [63:0] io_in_bits_data;
  logic        io_out_valid;
  logic        io_out_ready;
  logic [2:0]  io_out_bits_addr_beat;
  logic [1:0]  io_out_bits_client_xact_id;
  logic [0:0]  io_out_bits_manager_xact_id;
  logic        io_out_bits_is_builtin_type;
  logic [3:0]  io_out_bits_g_type;
  logic [63:0] io_out_bits_data;
  logic        io_finish_valid;
  logic        io_finish_ready;
  logic [0:0]  io_finish_bits_manager_xact_id;
  logic        io_beat_err;

  always #5 clk = ~clk;

  coreriscv_axi4_grant_finish_unit #(
    .GRANT_DEPTH  (GD),
    .FINISH_DEPTH (FD)
  ) dut (
    .clk                            (clk),
    .reset                          (reset),
    .io_in_valid                    (io_in_valid),
    .io_in_ready                    (io_in_ready),
    .io_in_bits_addr_beat           (io_in_bits_addr_beat),
    .io_in_bits_client_xact_id      (io_in_bits_client_xact_id),
    .io_in_bits_manager_xact_id     (io_in_bits_manager_xact_id),
    .io_in_bits_is_builtin_type     (io_in_bits_is_builtin_type),
    .io_in_bits_g_type              (io_in_bits_g_type),
    .io_in_bits_data                (io_in_bits_data),
    .io_out_valid                   (io_out_valid),
    .io_out_ready                   (io_out_ready),
    .io_out_bits_addr_beat          (io_out_bits_addr_beat),
    .io_out_bits_client_xact_id     (io_out_bits_client_xact_id),
    .io_out_bits_manager_xact_id    (io_out_bits_manager_xact_id),
    .io_out_bits_is_builtin_type    (io_out_bits_is_builtin_type),
    .io_out_bits_g_type             (io_out_bits_g_type),
    .io_out_bits_data               (io_out_bits_data),
    .io_finish_valid                (io_finish_valid),
    .io_finish_ready                (io_finish_ready),
    .io_finish_bits_manager_xact_id (io_finish_bits_manager_xact_id),
    .io_beat_err                    (io_beat_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  grant_t     gq[$];
  logic [0:0] fq[$];
  int         beats_done;   // beats of the current multibeat grant already accepted

  // Stimulus generator state: the beat currently offered
  grant_t pend;
  bit     pend_mb;
  int     gen_beat;
  bit     gen_active;
  bit     did_burst_reset;

  function automatic bit rule_multibeat(input grant_t g);
    return (g.is_builtin_type && g.g_type == 4'd5) || (!g.is_builtin_type && g.g_type == 4'd0);
  endfunction

  function automatic bit rule_needs_finish(input grant_t g);
    return !(g.is_builtin_type && g.g_type == 4'd0);
  endfunction

  task automatic new_grant();
    int kind;
    kind = $urandom_range(0, 4);
    case (kind)
      0: begin pend.is_builtin_type = 1'b1; pend.g_type = 4'd5; end
      1: begin pend.is_builtin_type = 1'b0; pend.g_type = 4'd0; end
      2: begin pend.is_builtin_type = 1'b1; pend.g_type = 4'd0; end
      3: begin
        pend.is_builtin_type = 1'b1;
        pend.g_type = 4'($urandom_range(1, 15));
        if (pend.g_type == 4'd5) pend.g_type = 4'd3;
      end
      default: begin pend.is_builtin_type = 1'b0; pend.g_type = 4'($urandom_range(1, 15)); end
    endcase
    pend.client_xact_id  = 2'($urandom_range(0, 3));
    pend.manager_xact_id = 1'($urandom_range(0, 1));
    pend_mb    = rule_multibeat(pend);
    gen_beat   = 0;
    gen_active = 1'b1;
    pend.addr_beat = 3'd0;
    pend.data      = {$urandom, $urandom};
  endtask

  task automatic drive_pend(input bit v);
    io_in_valid                = v;
    io_in_bits_addr_beat       = pend.addr_beat;
    io_in_bits_client_xact_id  = pend.client_xact_id;
    io_in_bits_manager_xact_id = pend.manager_xact_id;
    io_in_bits_is_builtin_type = pend.is_builtin_type;
    io_in_bits_g_type          = pend.g_type;
    io_in_bits_data            = pend.data;
  endtask

  function automatic grant_t dut_out();
    grant_t g;
    g.addr_beat       = io_out_bits_addr_beat;
    g.client_xact_id  = io_out_bits_client_xact_id;
    g.manager_xact_id = io_out_bits_manager_xact_id;
    g.is_builtin_type = io_out_bits_is_builtin_type;
    g.g_type          = io_out_bits_g_type;
    g.data            = io_out_bits_data;
    return g;
  endfunction

  task automatic model_clear();
    gq.delete();
    fq.delete();
    beats_done = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, 128'(io_out_valid), 128'(0));
    check({tag, "_fin_valid"}, 128'(io_finish_valid), 128'(0));
    check({tag, "_out_data"},  128'(io_out_bits_data), 128'(0));
    check({tag, "_beat_err"},  128'(io_beat_err), 128'(0));
  endtask

  initial begin
    bit     exp_ready, mb, need, last, in_fire, out_fire, fin_fire;
    int     p_out, p_fin;
    grant_t exp_head;

    reset = 1'b1;
    io_out_ready = 1'b0;
    io_finish_ready = 1'b0;
    new_grant();
    drive_pend(1'b0);
    model_clear();
    did_burst_reset = 1'b0;
    #12;
    check_reset_outputs("reset");
    check("reset_in_ready", 128'(io_in_ready), 128'(1));
    @(negedge clk);
    reset = 1'b0;

    for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
      @(negedge clk);
      // Alternate between free-flowing, output-stalled and finish-stalled traffic
      case ((cyc / 150) % 4)
        0: begin p_out = 95; p_fin = 95; end
        1: begin p_out = 25; p_fin = 80; end
        2: begin p_out = 90; p_fin = 10; end
        default: begin p_out = 50; p_fin = 50; end
      endcase
      io_out_ready    = ($urandom_range(1, 100) <= p_out);
      io_finish_ready = ($urandom_range(1, 100) <= p_fin);
      if (!gen_active) new_grant();
      drive_pend($urandom_range(1, 100) <= 80);

      // Reset in the middle of a burst, at its fourth beat
      if (!did_burst_reset && cyc > 700 && pend_mb && gen_beat == 3) begin
        did_burst_reset = 1'b1;
        reset = 1'b1;
        #1;
        check_reset_outputs("midburst_reset");
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        new_grant();
        continue;
      end

      #1;
      mb   = rule_multibeat(pend);
      need = rule_needs_finish(pend);
      last = !mb || (beats_done == BEATS_PER_BLOCK - 1);
      exp_ready = (gq.size() < GD) && ((fq.size() < FD) || !need || !last);

      check("in_ready", 128'(io_in_ready), 128'(exp_ready));
      check("out_valid", 128'(io_out_valid), 128'(gq.size() > 0));
      if (gq.size() > 0) begin
        exp_head = gq[0];
        check("out_bits", 128'(dut_out()), 128'(exp_head));
      end
      check("fin_valid", 128'(io_finish_valid), 128'(fq.size() > 0));
      if (fq.size() > 0) check("fin_id", 128'(io_finish_bits_manager_xact_id), 128'(fq[0]));
      check("beat_err", 128'(io_beat_err), 128'(0));

      in_fire  = io_in_valid && exp_ready;
      out_fire = io_out_ready && (gq.size() > 0);
      fin_fire = io_finish_ready && (fq.size() > 0);
      if (out_fire) void'(gq.pop_front());
      if (fin_fire) void'(fq.pop_front());
      if (in_fire) begin
        gq.push_back(pend);
        if (need && last) fq.push_back(pend.manager_xact_id);
        if (mb) beats_done = (beats_done + 1) % BEATS_PER_BLOCK;
        if (mb && gen_beat < BEATS_PER_BLOCK - 1) begin
          gen_beat++;
          pend.addr_beat = 3'(gen_beat);
          pend.data      = {$urandom, $urandom};
        end else begin
          gen_active = 1'b0;
        end
      end
    end

`ifdef CORERISCV_AXI4_GRANT_BEAT_CHECK_EN
    // Beat index 5 where 4 is expected must raise the sticky error flag
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    io_out_ready    = 1'b1;
    io_finish_ready = 1'b1;
    pend.is_builtin_type = 1'b0;
    pend.g_type          = 4'd0;
    for (int i = 0; i < 5; i++) begin
      pend.addr_beat = (i < 4) ? 3'(i) : 3'd5;
      pend.data      = {$urandom, $urandom};
      drive_pend(1'b1);
      @(negedge clk);
      if (i < 4) check("beat_err_clean", 128'(io_beat_err), 128'(0));
    end
    drive_pend(1'b0);
    check("beat_err_set", 128'(io_beat_err), 128'(1));
    @(negedge clk);
    check("beat_err_sticky", 128'(io_beat_err), 128'(1));
    reset = 1'b1;
    #1;
    check("beat_err_reset", 128'(io_beat_err), 128'(0));
    @(negedge clk);
    reset = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
